arc4_seq: RTL and testbench



---
 rtl/arc4_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_arc4_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_seq.sv
// ARC4 top-level sequencer.
// Runs init -> KSA -> PRGA through the rdy/en handshake of each sub-block and
// steers the single-port S memory to whichever phase currently owns it.
// A per-phase watchdog turns a sub-block that never finishes into a sticky err
// and parks the sequencer in HALT until reset.
module arc4_seq #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TW      = 13
) (
  input  logic       clk,
  input  logic       rst_n,

  // Wrapper handshake
  input  logic       en,
  output logic       rdy,
  output logic [1:0] phase,
  output logic       err,

  // Sub-block handshakes
  input  logic       init_rdy,
  input  logic       ksa_rdy,
  input  logic       prga_rdy,
  output logic       init_en,
  output logic       ksa_en,
  output logic       prga_en,

  // Per-phase S memory requests
  input  logic [7:0] init_addr,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] prga_addr,
  input  logic [7:0] init_wrdata,
  input  logic [7:0] ksa_wrdata,
  input  logic [7:0] prga_wrdata,
  input  logic       init_wren,
  input  logic       ksa_wren,
  input  logic       prga_wren,

  // Muxed S memory port
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  typedef enum logic [2:0] {
    StIdle,
    StGoInit,
    StWaitInit,
    StGoKsa,
    StWaitKsa,
    StGoPrga,
    StWaitPrga,
    StHalt
  } state_e;

  localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic          err_q, err_d;
  logic          init_en_q, init_en_d;
  logic          ksa_en_q, ksa_en_d;
  logic          prga_en_q, prga_en_d;
  logic [TW-1:0] wdog_q, wdog_d;
  // Set during the first WAIT cycle: the sub-block still shows the rdy it had
  // before seeing our en, so that cycle must not count as completion.
  logic          first_q, first_d;

  logic [TW-1:0] wdog_inc;
  logic          wdog_hit;

  assign wdog_inc = wdog_q + TW'(1);
  assign wdog_hit = (wdog_inc == TimeoutCnt);

  // State and registered outputs, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      err_q     <= 1'b0;
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
      wdog_q    <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      init_en_q <= init_en_d;
      ksa_en_q  <= ksa_en_d;
      prga_en_q <= prga_en_d;
      wdog_q    <= wdog_d;
      first_q   <= first_d;
    end
  end

  // Next state, start pulses, watchdog and sticky error
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    init_en_d = 1'b0;
    ksa_en_d  = 1'b0;
    prga_en_d = 1'b0;
    wdog_d    = wdog_q;
    first_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StGoInit;
      end

      StGoInit: begin
        if (init_rdy) begin
          init_en_d = 1'b1;
          wdog_d    = '0;
          first_d   = 1'b1;
          state_d   = StWaitInit;
        end
      end

      StWaitInit: begin
        wdog_d = wdog_inc;
        // Completion takes priority over an expiring watchdog
        if (!first_q && init_rdy) begin
          state_d = StGoKsa;
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end

      StGoKsa: begin
        if (ksa_rdy) begin
          ksa_en_d = 1'b1;
          wdog_d   = '0;
          first_d  = 1'b1;
          state_d  = StWaitKsa;
        end
      end

      StWaitKsa: begin
        wdog_d = wdog_inc;
        if (!first_q && ksa_rdy) begin
          state_d = StGoPrga;
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end

      StGoPrga: begin
        if (prga_rdy) begin
          prga_en_d = 1'b1;
          wdog_d    = '0;
          first_d   = 1'b1;
          state_d   = StWaitPrga;
        end
      end

      StWaitPrga: begin
        wdog_d = wdog_inc;
        if (!first_q && prga_rdy) begin
          state_d = StIdle;
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end

      StHalt: begin
        // Only rst_n leaves HALT
        state_d = StHalt;
      end

      default: state_d = StIdle;
    endcase
  end

  // Registered phase tracks the next state; HALT keeps the failing phase
  always_comb begin
    phase_d = phase_q;
    unique case (state_d)
      StIdle:                 phase_d = 2'd0;
      StGoInit, StWaitInit:   phase_d = 2'd1;
      StGoKsa, StWaitKsa:     phase_d = 2'd2;
      StGoPrga, StWaitPrga:   phase_d = 2'd3;
      StHalt:                 phase_d = phase_q;
      default:                phase_d = 2'd0;
    endcase
  end

  // S memory mux from registered state: owner gets the port with no added
  // latency, writes only pass while the owner is actually running
  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    unique case (state_q)
      StGoInit: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
      end
      StWaitInit: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      StGoKsa: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
      end
      StWaitKsa: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      StGoPrga: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
      end
      StWaitPrga: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
      end
    endcase
  end

  // Wrapper-facing status
  always_comb begin
    rdy     = (state_q == StIdle);
    phase   = phase_q;
    err     = err_q;
    init_en = init_en_q;
    ksa_en  = ksa_en_q;
    prga_en = prga_en_q;
  end

endmodule

// File: tb/tb_arc4_seq.sv
// Directed bench for arc4_seq: a full run against busy-counter sub-block
// models, plus a second instance with a short watchdog for timeout cases.
module tb_arc4_seq;

  localparam int unsigned InitBusy = 256;
  localparam int unsigned KsaBusy  = 768;
  localparam int unsigned PrgaBusy = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Main instance (default TIMEOUT)
  logic       rst_n, en, rdy, err;
  logic [1:0] phase;
  logic       init_rdy, ksa_rdy, prga_rdy, init_en, ksa_en, prga_en;
  logic [7:0] init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata;
  logic       init_wren, ksa_wren, prga_wren;
  logic [7:0] s_addr, s_wrdata;
  logic       s_wren;

  arc4_seq u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .phase(phase), .err(err),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  // Short-watchdog instance
  logic       rst2_n, en2, rdy2, err2;
  logic [1:0] phase2;
  logic       init_rdy2, ksa_rdy2, prga_rdy2, init_en2, ksa_en2, prga_en2;
  logic [7:0] s_addr2, s_wrdata2;
  logic       s_wren2;

  arc4_seq #(.TIMEOUT(16), .TW(5)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .rdy(rdy2), .phase(phase2), .err(err2),
    .init_rdy(init_rdy2), .ksa_rdy(ksa_rdy2), .prga_rdy(prga_rdy2),
    .init_en(init_en2), .ksa_en(ksa_en2), .prga_en(prga_en2),
    .init_addr(8'h01), .ksa_addr(8'h33), .prga_addr(8'h02),
    .init_wrdata(8'h03), .ksa_wrdata(8'h44), .prga_wrdata(8'h04),
    .init_wren(1'b0), .ksa_wren(1'b1), .prga_wren(1'b0),
    .s_addr(s_addr2), .s_wrdata(s_wrdata2), .s_wren(s_wren2)
  );

  // Sub-block models: rdy drops the cycle after en, stays low for N cycles
  int unsigned init_cnt, ksa_cnt, prga_cnt;
  logic        ksa_hold;

  assign init_rdy = (init_cnt == 0);
  assign ksa_rdy  = (ksa_cnt == 0) && !ksa_hold;
  assign prga_rdy = (prga_cnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= 0;
      ksa_cnt  <= 0;
      prga_cnt <= 0;
    end else begin
      if (init_en) init_cnt <= InitBusy;
      else if (init_cnt != 0) init_cnt <= init_cnt - 1;
      if (ksa_en) ksa_cnt <= KsaBusy;
      else if (ksa_cnt != 0) ksa_cnt <= ksa_cnt - 1;
      if (prga_en) prga_cnt <= PrgaBusy;
      else if (prga_cnt != 0) prga_cnt <= prga_cnt - 1;
    end
  end

  // Start-pulse order and phase-change trace of the main instance
  int         ev_log[$];
  int         ph_log[$];
  logic [1:0] ph_last = 2'd0;
  int         n_init2 = 0;

  always @(posedge clk) begin
    if (init_en) ev_log.push_back(1);
    if (ksa_en) ev_log.push_back(2);
    if (prga_en) ev_log.push_back(3);
    if (phase != ph_last) begin
      ph_log.push_back(int'(phase));
      ph_last <= phase;
    end
    if (init_en2) n_init2 <= n_init2 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && rdy !== 1'b1; i++) step(1);
    check_eq(tag, 32'(rdy), 32'd1);
  endtask

  task automatic wait_phase2(input string tag);
    for (int i = 0; i < 400 && phase !== 2'd2; i++) step(1);
    check_eq(tag, 32'(phase), 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base_ev, base_ph, n_ini, base_n2, cnt;

    rst_n = 1'b1; rst2_n = 1'b1; en = 1'b0; en2 = 1'b0; ksa_hold = 1'b0;
    init_wren = 1'b1; init_addr = 8'h2A; init_wrdata = 8'h2A;
    ksa_wren  = 1'b1; ksa_addr  = 8'h10; ksa_wrdata  = 8'h55;
    prga_wren = 1'b1; prga_addr = 8'h77; prga_wrdata = 8'h99;
    init_rdy2 = 1'b1; ksa_rdy2 = 1'b1; prga_rdy2 = 1'b1;

    #1 rst_n = 1'b0; rst2_n = 1'b0;
    #2;
    check_eq("rst_rdy", 32'(rdy), 32'd1);
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_init_en", 32'(init_en), 32'd0);
    check_eq("rst_s_wren", 32'(s_wren), 32'd0);
    check_eq("rst_s_addr", 32'(s_addr), 32'd0);
    check_eq("rst_s_wrdata", 32'(s_wrdata), 32'd0);
    step(2);
    rst_n = 1'b1; rst2_n = 1'b1;
    step(2);
    check_eq("idle_s_wren", 32'(s_wren), 32'd0);

    // Run 1: full sequence, latency and mux during init
    base_ev = ev_log.size();
    base_ph = ph_log.size();
    en = 1'b1; step(1); en = 1'b0;
    check_eq("rdy_drop", 32'(rdy), 32'd0);
    check_eq("go_init_phase", 32'(phase), 32'd1);
    check_eq("init_en_early", 32'(init_en), 32'd0);
    step(1);
    check_eq("init_en_lat2", 32'(init_en), 32'd1);
    check_eq("mux_init_addr", 32'(s_addr), 32'h2A);
    check_eq("mux_init_wrdata", 32'(s_wrdata), 32'h2A);
    check_eq("mux_init_wren", 32'(s_wren), 32'd1);
    wait_done("run1_done");
    check_eq("run1_err", 32'(err), 32'd0);
    step(1);
    check_eq("run1_pulses", 32'(ev_log.size() - base_ev), 32'd3);
    if (ev_log.size() - base_ev == 3) begin
      check_eq("run1_order0", 32'(ev_log[base_ev]), 32'd1);
      check_eq("run1_order1", 32'(ev_log[base_ev + 1]), 32'd2);
      check_eq("run1_order2", 32'(ev_log[base_ev + 2]), 32'd3);
    end
    check_eq("run1_phase_steps", 32'(ph_log.size() - base_ph), 32'd4);
    if (ph_log.size() - base_ph == 4) begin
      check_eq("run1_ph0", 32'(ph_log[base_ph]), 32'd1);
      check_eq("run1_ph1", 32'(ph_log[base_ph + 1]), 32'd2);
      check_eq("run1_ph2", 32'(ph_log[base_ph + 2]), 32'd3);
      check_eq("run1_ph3", 32'(ph_log[base_ph + 3]), 32'd0);
    end

    // Run 2: KSA not ready for 5 cycles, then en while busy
    ksa_hold = 1'b1;
    base_ev = ev_log.size();
    en = 1'b1; step(1); en = 1'b0;
    wait_phase2("go_ksa_reached");
    for (int k = 0; k < 5; k++) begin
      check_eq("go_ksa_no_en", 32'(ksa_en), 32'd0);
      check_eq("go_ksa_no_wren", 32'(s_wren), 32'd0);
      step(1);
    end
    check_eq("go_ksa_phase", 32'(phase), 32'd2);
    ksa_hold = 1'b0;
    step(1);
    check_eq("ksa_en_on_rdy", 32'(ksa_en), 32'd1);
    check_eq("mux_ksa_wren", 32'(s_wren), 32'd1);
    check_eq("mux_ksa_addr", 32'(s_addr), 32'h10);
    check_eq("mux_ksa_wrdata", 32'(s_wrdata), 32'h55);
    step(5);
    en = 1'b1; step(1); en = 1'b0;
    check_eq("busy_en_phase", 32'(phase), 32'd2);
    wait_done("run2_done");
    step(1);
    n_ini = 0;
    for (int i = base_ev; i < ev_log.size(); i++) if (ev_log[i] == 1) n_ini++;
    check_eq("busy_en_one_init", 32'(n_ini), 32'd1);
    check_eq("run2_pulses", 32'(ev_log.size() - base_ev), 32'd3);

    // Run 3: asynchronous reset in WAIT_KSA, then restart
    en = 1'b1; step(1); en = 1'b0;
    wait_phase2("run3_ksa");
    step(20);
    check_eq("run3_pre_wren", 32'(s_wren), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrst_rdy", 32'(rdy), 32'd1);
    check_eq("midrst_phase", 32'(phase), 32'd0);
    check_eq("midrst_wren", 32'(s_wren), 32'd0);
    check_eq("midrst_err", 32'(err), 32'd0);
    #2 rst_n = 1'b1;
    step(1);
    en = 1'b1; step(1); en = 1'b0;
    step(1);
    check_eq("restart_init_en", 32'(init_en), 32'd1);
    check_eq("restart_phase", 32'(phase), 32'd1);
    wait_done("run3_done");

    // Short watchdog: rdy returns in the expiry cycle, completion wins
    en2 = 1'b1; step(1); en2 = 1'b0;
    for (int i = 0; i < 20 && ksa_en2 !== 1'b1; i++) step(1);
    check_eq("wd_ok_ksa_en", 32'(ksa_en2), 32'd1);
    ksa_rdy2 = 1'b0;
    step(15);
    check_eq("wd_ok_no_err_yet", 32'(err2), 32'd0);
    ksa_rdy2 = 1'b1;
    step(1);
    check_eq("wd_tie_err", 32'(err2), 32'd0);
    check_eq("wd_tie_phase", 32'(phase2), 32'd3);
    for (int i = 0; i < 20 && rdy2 !== 1'b1; i++) step(1);
    check_eq("wd_tie_done", 32'(rdy2), 32'd1);

    // Short watchdog: KSA never finishes
    en2 = 1'b1; step(1); en2 = 1'b0;
    for (int i = 0; i < 20 && ksa_en2 !== 1'b1; i++) step(1);
    check_eq("wd_ksa_en", 32'(ksa_en2), 32'd1);
    ksa_rdy2 = 1'b0;
    cnt = 0;
    while (cnt < 100 && err2 !== 1'b1) begin
      step(1);
      cnt++;
    end
    check_eq("wd_cycles", 32'(cnt), 32'd16);
    check_eq("wd_phase", 32'(phase2), 32'd2);
    check_eq("wd_rdy", 32'(rdy2), 32'd0);
    check_eq("wd_halt_wren", 32'(s_wren2), 32'd0);
    check_eq("wd_halt_addr", 32'(s_addr2), 32'd0);
    base_n2 = n_init2;
    en2 = 1'b1; step(1); en2 = 1'b0;
    step(3);
    check_eq("halt_en_ignored", 32'(n_init2 - base_n2), 32'd0);
    check_eq("halt_err_sticky", 32'(err2), 32'd1);
    check_eq("halt_phase", 32'(phase2), 32'd2);
    check_eq("halt_rdy", 32'(rdy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
